// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer handlers.
//   DEF_ADDR_W / DEF_AFULL_THRESH : default geometry and almost-full threshold
//   bin2gray / gray2bin           : code conversions. They work on 32 bits, so
//                                   any narrower pointer converts correctly when
//                                   zero-extended in and truncated out.
package fifo_pkg;

  localparam int DEF_ADDR_W       = 3;
  localparam int DEF_AFULL_THRESH = 6;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Purely combinational Gray-to-binary decoder. It is shared by the write-side
// and read-side pointer handlers.
//   i_gray [WIDTH-1:0] : Gray-coded value
//   o_bin  [WIDTH-1:0] : binary value; bit i is the XOR of gray bits WIDTH-1..i
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule

// File: rtl/wptr_level_handler.sv
// Write-side pointer handler for the dual-clock FIFO (wclk domain).
// It keeps the binary and Gray write pointers, the fill level as seen from the
// write side, the full and almost-full flags, and a sticky overflow flag.
//   wclk, wrst     : write clock, asynchronous active-low reset
//   w_en, ovf_clr  : write request, clear for the sticky overflow flag
//   g_rptr_sync    : Gray read pointer, already synchronised into wclk
//   b_wptr, g_wptr : binary and Gray write pointers (ADDR_W+1 bits)
//   waddr          : memory write address
//   w_accept       : combinational memory write enable (w_en && !full)
//   full, almost_full, w_level, overflow : registered status
module wptr_level_handler
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              w_en,
  input  logic              ovf_clr,
  input  logic [ADDR_W:0]   g_rptr_sync,
  output logic [ADDR_W:0]   b_wptr,
  output logic [ADDR_W:0]   g_wptr,
  output logic [ADDR_W-1:0] waddr,
  output logic              w_accept,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   w_level,
  output logic              overflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  if ((ADDR_W < 2) || (AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_param_err
    $error("wptr_level_handler: need ADDR_W >= 2 and 1 <= AFULL_THRESH <= 2**ADDR_W");
  end

  logic [PTR_W-1:0] r_b_wptr;
  logic [PTR_W-1:0] r_g_wptr;
  logic             r_full;
  logic             r_almost_full;
  logic [PTR_W-1:0] r_level;
  logic             r_overflow;

  logic [PTR_W-1:0] w_b_rptr_sync;
  logic [PTR_W-1:0] w_b_wptr_next;
  logic [PTR_W-1:0] w_g_wptr_next;
  logic [PTR_W-1:0] w_level_next;
  logic             w_full_next;
  logic             w_afull_next;
  logic             w_ovf_next;

  gray2bin_conv #(.WIDTH(PTR_W)) u_rptr_dec (
    .i_gray (g_rptr_sync),
    .o_bin  (w_b_rptr_sync)
  );

  assign w_accept      = w_en && !r_full;
  assign w_b_wptr_next = r_b_wptr + PTR_W'(w_accept);
  assign w_g_wptr_next = PTR_W'(bin2gray(32'(w_b_wptr_next)));
  assign w_level_next  = w_b_wptr_next - w_b_rptr_sync;

  // Full when the write pointer is exactly one lap ahead: in Gray code that
  // means the top two bits differ and the rest match.
  assign w_full_next  = (w_g_wptr_next ==
                         {~g_rptr_sync[ADDR_W:ADDR_W-1], g_rptr_sync[ADDR_W-2:0]});
  assign w_afull_next = (w_level_next >= PTR_W'(AFULL_THRESH));
  // A fresh overflow wins over a simultaneous clear.
  assign w_ovf_next   = (w_en && r_full) || (r_overflow && !ovf_clr);

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      r_b_wptr      <= '0;
      r_g_wptr      <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_b_wptr      <= w_b_wptr_next;
      r_g_wptr      <= w_g_wptr_next;
      r_full        <= w_full_next;
      r_almost_full <= w_afull_next;
      r_level       <= w_level_next;
      r_overflow    <= w_ovf_next;
    end
  end

  assign b_wptr      = r_b_wptr;
  assign g_wptr      = r_g_wptr;
  assign waddr       = r_b_wptr[ADDR_W-1:0];
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign w_level     = r_level;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_wptr_level_handler.sv
module tb_wptr_level_handler;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          w_en;
  logic          ovf_clr;
  logic [AW:0]   g_rptr_sync;
  logic [AW:0]   b_wptr;
  logic [AW:0]   g_wptr;
  logic [AW-1:0] waddr;
  logic          w_accept;
  logic          full;
  logic          almost_full;
  logic [AW:0]   w_level;
  logic          overflow;

  wptr_level_handler #(.ADDR_W(AW), .AFULL_THRESH(AF)) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .w_en        (w_en),
    .ovf_clr     (ovf_clr),
    .g_rptr_sync (g_rptr_sync),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .waddr       (waddr),
    .w_accept    (w_accept),
    .full        (full),
    .almost_full (almost_full),
    .w_level     (w_level),
    .overflow    (overflow)
  );

  always #5 wclk = ~wclk;

  int total = 0;
  int bad   = 0;

  // Reference model: total writes accepted and total read advances since reset.
  int wtot;
  int rtot;
  bit m_ovf;
  bit saw_full;
  bit saw_wrap;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic int m_level();
    return wtot - rtot;
  endfunction

  function automatic bit m_full();
    return m_level() == DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("b_wptr",      32'(b_wptr),      32'(wtot % 16));
    chk("g_wptr",      32'(g_wptr),      32'(gray(wtot % 16)));
    chk("waddr",       32'(waddr),       32'(wtot % 8));
    chk("full",        32'(full),        32'(m_full()));
    chk("almost_full", 32'(almost_full), 32'(m_level() >= AF));
    chk("w_level",     32'(w_level),     32'(m_level()));
    chk("overflow",    32'(overflow),    32'(m_ovf));
  endtask

  // One clock cycle: apply inputs mid-cycle, check the write strobe, clock,
  // advance the model and check every registered output.
  task automatic cycle(input bit en, input bit clr, input int radv);
    bit acc;
    bit was_full;
    w_en        = en;
    ovf_clr     = clr;
    rtot        = rtot + radv;
    g_rptr_sync = gray(rtot % 16);
    was_full    = (wtot - (rtot - radv)) == DEPTH;
    acc         = en && !was_full;
    #1;
    chk("w_accept", 32'(w_accept), 32'(acc));
    @(posedge wclk);
    #1;
    if (acc) wtot++;
    if (en && was_full) m_ovf = 1'b1;
    else if (clr)       m_ovf = 1'b0;
    check_state();
    if (full === 1'b1) saw_full = 1'b1;
    if ((b_wptr === 4'd0) && acc) saw_wrap = 1'b1;
  endtask

  // Synchronous-looking entry into reset plus release; model reset with it.
  task automatic do_reset();
    wrst = 1'b0;
    w_en = 1'b0;
    ovf_clr = 1'b0;
    g_rptr_sync = '0;
    wtot = 0; rtot = 0; m_ovf = 1'b0;
    #1;
    check_state();
    @(negedge wclk);
    wrst = 1'b1;
    @(posedge wclk);
    #1;
    check_state();
  endtask

  initial begin
    wrst = 1'b0; w_en = 1'b0; ovf_clr = 1'b0; g_rptr_sync = '0;
    wtot = 0; rtot = 0; m_ovf = 1'b0;
    saw_full = 1'b0; saw_wrap = 1'b0;
    #12;
    check_state();
    @(negedge wclk);
    wrst = 1'b1;
    @(posedge wclk);
    #1;

    // 1: reset in the middle of a write burst, w_en still high
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    chk("pre_reset_b_wptr", 32'(b_wptr), 32'd3);
    w_en = 1'b1;
    #2;
    wrst = 1'b0;
    g_rptr_sync = '0;
    wtot = 0; rtot = 0; m_ovf = 1'b0;
    #1;
    check_state();
    chk("reset_w_accept", 32'(w_accept), 32'd1);
    @(negedge wclk);
    wrst = 1'b1;
    w_en = 1'b0;
    @(posedge wclk);
    #1;
    check_state();
    cycle(1, 0, 0);
    chk("first_write_b", 32'(b_wptr), 32'd1);
    chk("first_write_g", 32'(g_wptr), 32'd1);

    // 2: fill from empty
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 0, 0);
      chk("fill_afull", 32'(almost_full), 32'(i >= 6));
    end
    chk("fill_g_wptr_C", 32'(g_wptr), 32'hC);
    chk("fill_level8", 32'(w_level), 32'd8);
    chk("fill_full", 32'(full), 32'd1);

    // 3: overflow while full, clear behaviour
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("ovf_b_wptr_hold", 32'(b_wptr), 32'd8);
    chk("ovf_set", 32'(overflow), 32'd1);
    cycle(0, 1, 0);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    cycle(0, 1, 0);

    // 4: drain seen from the write side
    cycle(0, 0, 1);
    chk("drain_full_clear", 32'(full), 32'd0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("drain_level5", 32'(w_level), 32'd5);
    chk("drain_afull0", 32'(almost_full), 32'd0);

    // 6: simultaneous write and read advance at level 8
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    chk("sim_full_before", 32'(full), 32'd1);
    cycle(1, 0, 1);
    chk("sim_full_drop", 32'(full), 32'd0);
    cycle(1, 0, 0);
    chk("sim_full_back", 32'(full), 32'd1);
    chk("sim_level8", 32'(w_level), 32'd8);

    // 5: wrap-around with the read pointer trailing by two
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    saw_full = 1'b0;
    saw_wrap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 1);
      chk("wrap_level2", 32'(w_level), 32'd2);
    end
    chk("wrap_seen", 32'(saw_wrap), 32'd1);
    chk("wrap_never_full", 32'(saw_full), 32'd0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit en;
      bit clr;
      int radv;
      en   = (i % 80 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 7) == 0);
      radv = ((rtot < wtot) && ($urandom_range(0, 1) == 1)) ? 1 : 0;
      cycle(en, clr, radv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
